// File: rtl/fetch_unit.sv
// LEGv8 instruction fetch: PC, single-outstanding imem request/response, instruction queue.
// Optional B-instruction predecode enabled by defining FETCH_BRANCH_PREDECODE_EN.
module fetch_unit #(
   parameter int unsigned       PC_W        = 64,
   parameter logic [PC_W-1:0]   RESET_PC    = '0,
   parameter int unsigned       QUEUE_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   output logic [PC_W-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            inst_valid,
   output logic [31:0]     inst_data,
   output logic [PC_W-1:0] inst_pc,
   output logic            inst_predicted,
   input  logic            inst_ready,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc
);

   localparam int unsigned     PtrW  = $clog2(QUEUE_DEPTH);
   localparam int unsigned     CntW  = PtrW + 1;
   localparam logic [CntW-1:0] Depth = CntW'(QUEUE_DEPTH);

   typedef enum logic [1:0] {StFetch, StWait, StDiscard} state_e;

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] req_pc_q, req_pc_d;
   logic [CntW-1:0] count_q, count_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]     data_q [QUEUE_DEPTH];
   logic [PC_W-1:0] qpc_q  [QUEUE_DEPTH];

   logic            accept, deq, enq;
   logic [PC_W-1:0] next_pc;
   logic            unused_redirect_lsb;

   assign unused_redirect_lsb = ^redirect_pc[1:0];

   assign imem_req_valid = ~reset & (state_q == StFetch) & (count_q < Depth);
   assign imem_req_addr  = pc_q;
   assign accept         = imem_req_valid & imem_req_ready;
   assign inst_valid     = (count_q != '0);
   assign deq            = inst_valid & inst_ready;
   // A redirect drops any response arriving in the same cycle.
   assign enq            = (state_q == StWait) & imem_rsp_valid & ~redirect_valid;
   assign inst_data      = data_q[rd_ptr_q];
   assign inst_pc        = qpc_q[rd_ptr_q];

`ifdef FETCH_BRANCH_PREDECODE_EN
   logic                   enq_pred;
   logic [QUEUE_DEPTH-1:0] pred_q;

   always_comb begin
      next_pc  = req_pc_q + PC_W'(4);
      enq_pred = 1'b0;
      if (imem_rsp_data[31:26] == 6'b000101) begin
         next_pc  = req_pc_q + {{(PC_W-28){imem_rsp_data[25]}}, imem_rsp_data[25:0], 2'b00};
         enq_pred = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pred_q <= '0;
      end else if (enq) begin
         pred_q[wr_ptr_q] <= enq_pred;
      end
   end

   assign inst_predicted = pred_q[rd_ptr_q];
`else
   always_comb begin
      next_pc = req_pc_q + PC_W'(4);
   end

   assign inst_predicted = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;

      case (state_q)
         StFetch: begin
            if (accept) begin
               req_pc_d = pc_q;
               state_d  = StWait;
            end
         end
         StWait: begin
            if (imem_rsp_valid) begin
               pc_d    = next_pc;
               state_d = StFetch;
            end
         end
         StDiscard: begin
            if (imem_rsp_valid) begin
               state_d = StFetch;
            end
         end
         default: state_d = StFetch;
      endcase

      if (enq) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (deq) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({enq, deq})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase

      // A request accepted this cycle is still outstanding and must be discarded.
      if (redirect_valid) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         pc_d     = {redirect_pc[PC_W-1:2], 2'b00};
         state_d  = (((state_q == StWait) && !imem_rsp_valid) || accept) ? StDiscard : StFetch;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StFetch;
         pc_q     <= RESET_PC;
         req_pc_q <= '0;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            data_q[i] <= '0;
            qpc_q[i]  <= '0;
         end
      end else if (enq) begin
         data_q[wr_ptr_q] <= imem_rsp_data;
         qpc_q[wr_ptr_q]  <= req_pc_q;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit (RESET_PC=0x100, QUEUE_DEPTH=2).
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic [63:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [63:0] inst_pc;
   logic        inst_predicted;
   logic        inst_ready;
   logic        redirect_valid;
   logic [63:0] redirect_pc;

   int n_tests = 0;
   int n_fail  = 0;

   fetch_unit #(
      .PC_W        (64),
      .RESET_PC    (64'h100),
      .QUEUE_DEPTH (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_predicted (inst_predicted),
      .inst_ready     (inst_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

`ifdef FETCH_BRANCH_PREDECODE_EN
   localparam logic [63:0] BTarget = 64'h38;
   localparam logic [63:0] BPred   = 64'd1;
`else
   localparam logic [63:0] BTarget = 64'h44;
   localparam logic [63:0] BPred   = 64'd0;
`endif

   initial begin
      reset          = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      tick();
      tick();
      chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
      chk("rst_req_addr", imem_req_addr, 64'h100);
      chk("rst_inst_valid", 64'(inst_valid), 64'd0);
      chk("rst_inst_data", 64'(inst_data), 64'd0);
      chk("rst_inst_pc", inst_pc, 64'd0);
      chk("rst_inst_pred", 64'(inst_predicted), 64'd0);
      reset = 1'b0;
      #1;
      chk("first_req_valid", 64'(imem_req_valid), 64'd1);

      // Basic fetch at RESET_PC.
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      chk("wait_no_req", 64'(imem_req_valid), 64'd0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h8B020020;
      tick();
      imem_rsp_valid = 1'b0;
      chk("basic_valid", 64'(inst_valid), 64'd1);
      chk("basic_data", 64'(inst_data), 64'h8B020020);
      chk("basic_pc", inst_pc, 64'h100);
      chk("basic_next_addr", imem_req_addr, 64'h104);
      chk("basic_req_valid", 64'(imem_req_valid), 64'd1);

      // Redirect in FETCH with a queued entry being dequeued.
      redirect_valid = 1'b1;
      redirect_pc    = 64'h0;
      tick();
      redirect_valid = 1'b0;
      inst_ready     = 1'b0;
      chk("redir0_inst_valid", 64'(inst_valid), 64'd0);
      chk("redir0_addr", imem_req_addr, 64'h0);

      // Backpressure: two fetches fill the queue, then requests stop.
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hAAAA0001;
      tick();
      imem_rsp_valid = 1'b0;
      chk("bp1_pc", inst_pc, 64'h0);
      chk("bp1_req_valid", 64'(imem_req_valid), 64'd1);
      chk("bp1_addr", imem_req_addr, 64'h4);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hAAAA0002;
      tick();
      imem_rsp_valid = 1'b0;
      chk("bp_full_req_valid", 64'(imem_req_valid), 64'd0);
      chk("bp_full_head_pc", inst_pc, 64'h0);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      chk("bp_still_stalled", 64'(imem_req_valid), 64'd0);
      chk("bp_stalled_addr", imem_req_addr, 64'h8);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      chk("deq_head_pc", inst_pc, 64'h4);
      chk("deq_head_data", 64'(inst_data), 64'hAAAA0002);
      chk("deq_resume_req", 64'(imem_req_valid), 64'd1);
      chk("deq_resume_addr", imem_req_addr, 64'h8);

      // Redirect together with a response and a dequeue.
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h11111111;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h300;
      inst_ready     = 1'b1;
      tick();
      imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0;
      inst_ready     = 1'b0;
      chk("redir_rsp_inst_valid", 64'(inst_valid), 64'd0);
      chk("redir_rsp_req_valid", 64'(imem_req_valid), 64'd1);
      chk("redir_rsp_addr", imem_req_addr, 64'h300);

      // Redirect in WAIT; late response is discarded.
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h203;
      tick();
      redirect_valid = 1'b0;
      chk("discard_no_req", 64'(imem_req_valid), 64'd0);
      chk("discard_addr", imem_req_addr, 64'h200);
      tick();
      tick();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEADBEEF;
      tick();
      chk("discard_inst_valid", 64'(inst_valid), 64'd0);
      chk("discard_req_valid", 64'(imem_req_valid), 64'd1);
      // Response while in FETCH is ignored.
      tick();
      imem_rsp_valid = 1'b0;
      chk("fetch_rsp_ignored", 64'(inst_valid), 64'd0);
      chk("fetch_rsp_addr", imem_req_addr, 64'h200);

      // Redirect coinciding with request acceptance goes to DISCARD.
      imem_req_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h400;
      tick();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b0;
      chk("redir_acc_no_req", 64'(imem_req_valid), 64'd0);
      chk("redir_acc_addr", imem_req_addr, 64'h400);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h22222222;
      tick();
      imem_rsp_valid = 1'b0;
      chk("redir_acc_dropped", 64'(inst_valid), 64'd0);
      chk("redir_acc_resume", 64'(imem_req_valid), 64'd1);

      // PC wrap at the top of the address space.
      redirect_valid = 1'b1;
      redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
      tick();
      redirect_valid = 1'b0;
      chk("wrap_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h8B000000;
      tick();
      imem_rsp_valid = 1'b0;
      chk("wrap_inst_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_next_addr", imem_req_addr, 64'h0);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      chk("wrap_drained", 64'(inst_valid), 64'd0);

      // B predecode (build dependent), then BL which is never predecoded.
      redirect_valid = 1'b1;
      redirect_pc    = 64'h40;
      tick();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h17FFFFFE;
      tick();
      imem_rsp_valid = 1'b0;
      chk("b_pred", 64'(inst_predicted), BPred);
      chk("b_next_addr", imem_req_addr, BTarget);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h97FFFFFE;
      tick();
      imem_rsp_valid = 1'b0;
      chk("bl_next_addr", imem_req_addr, BTarget + 64'h4);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      chk("bl_pc", inst_pc, BTarget);
      chk("bl_not_pred", 64'(inst_predicted), 64'd0);

      // Reset during WAIT; response after reset is ignored.
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      reset          = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h33333333;
      tick();
      reset = 1'b0;
      tick();
      imem_rsp_valid = 1'b0;
      chk("rst_wait_inst_valid", 64'(inst_valid), 64'd0);
      chk("rst_wait_addr", imem_req_addr, 64'h100);
      chk("rst_wait_req_valid", 64'(imem_req_valid), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
